fetch_stage: RTL and testbench

Instruction fetch stage of the pipelined RV64 core. Holds the program counter and issues one instruction-memory request at a time over a valid/ready request channel plus a response-valid channel. Registers the returned instruction with its PC and PC+4 into the IF/ID pipeline register, which feeds the decode stage. Honours hazard-unit stall, decode flush and execute-stage branch/jump redirects, and discards responses made stale by a redirect.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_stage_preg.sv | 55 +++++
 rtl/fetch_stage.sv | 127 ++++++++++++
 tb/tb_fetch_stage.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
package fetch_pkg;

  typedef logic [1:0] fetch_state_t;

  // Fetch FSM states
  localparam fetch_state_t S_REQ  = 2'd0;  // presenting a request
  localparam fetch_state_t S_WAIT = 2'd1;  // request accepted, awaiting response
  localparam fetch_state_t S_HOLD = 2'd2;  // response parked while decode is stalled
  localparam fetch_state_t S_DROP = 2'd3;  // awaiting a response made stale by a redirect

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_preg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, otherwise a bubble.
module preg_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_flush,
  input  logic                   i_stall,
  input  logic                   i_load,
  input  logic [INSTR_WIDTH-1:0] i_instr,
  input  logic [ADDR_WIDTH-1:0]  i_pc,
  output logic [INSTR_WIDTH-1:0] o_instruction,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic [ADDR_WIDTH-1:0]  o_pc_plus4,
  output logic                   o_instr_valid
);

  localparam logic [INSTR_WIDTH-1:0] Nop = INSTR_WIDTH'(NOP_INSTR);

  logic [INSTR_WIDTH-1:0] instr_q;
  logic [ADDR_WIDTH-1:0]  pc_q;
  logic [ADDR_WIDTH-1:0]  pc_plus4_q;
  logic                   valid_q;

  // Register update; reset and flush both leave a bubble with zeroed PCs
  always_ff @(posedge i_clk) begin
    if (i_arst || i_flush) begin
      instr_q    <= Nop;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (!i_stall) begin
      if (i_load) begin
        instr_q    <= i_instr;
        pc_q       <= i_pc;
        pc_plus4_q <= i_pc + ADDR_WIDTH'(4);
        valid_q    <= 1'b1;
      end else begin
        instr_q    <= Nop;
        pc_q       <= '0;
        pc_plus4_q <= '0;
        valid_q    <= 1'b0;
      end
    end
  end

  assign o_instruction = instr_q;
  assign o_pc          = pc_q;
  assign o_pc_plus4    = pc_plus4_q;
  assign o_instr_valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding memory request FSM and IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 64,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_stall_fetch,
  input  logic                   i_flush_dec,
  input  logic                   i_redirect,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
  output logic                   o_mem_req_valid,
  output logic [ADDR_WIDTH-1:0]  o_mem_req_addr,
  input  logic                   i_mem_req_ready,
  input  logic                   i_mem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] i_mem_rsp_data,
  output logic [INSTR_WIDTH-1:0] o_instruction,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic [ADDR_WIDTH-1:0]  o_pc_plus4,
  output logic                   o_instr_valid
);

  fetch_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] hold_instr_q, hold_instr_d;
  logic [ADDR_WIDTH-1:0]  hold_pc_q, hold_pc_d;
  logic                   load;
  logic [INSTR_WIDTH-1:0] load_instr;
  logic [ADDR_WIDTH-1:0]  load_pc;
  logic                   req_fire;

  // Request channel depends only on state and PC, never on ready
  assign o_mem_req_valid = (state_q == S_REQ) && !i_arst;
  assign o_mem_req_addr  = pc_q;
  assign req_fire        = o_mem_req_valid && i_mem_req_ready;

  // Next-state, PC and IF/ID load selection; a redirect overrides everything else
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    load         = 1'b0;
    load_instr   = i_mem_rsp_data;
    load_pc      = pc_q;

    if (i_redirect) begin
      pc_d = i_redirect_pc & ~ADDR_WIDTH'(3);
      // Any request already in flight must have its response swallowed
      unique case (state_q)
        S_REQ:   state_d = req_fire ? S_DROP : S_REQ;
        S_WAIT:  state_d = i_mem_rsp_valid ? S_REQ : S_DROP;
        S_HOLD:  state_d = S_REQ;
        S_DROP:  state_d = i_mem_rsp_valid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (req_fire) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (i_mem_rsp_valid) begin
            if (i_stall_fetch) begin
              hold_instr_d = i_mem_rsp_data;
              hold_pc_d    = pc_q;
              state_d      = S_HOLD;
            end else begin
              load    = 1'b1;
              pc_d    = pc_q + ADDR_WIDTH'(4);
              state_d = S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!i_stall_fetch) begin
            load       = 1'b1;
            load_instr = hold_instr_q;
            load_pc    = hold_pc_q;
            pc_d       = pc_q + ADDR_WIDTH'(4);
            state_d    = S_REQ;
          end
        end
        S_DROP: begin
          if (i_mem_rsp_valid) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  // FSM, PC and hold buffer state
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  preg_fetch #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_preg (
    .i_clk         (i_clk),
    .i_arst        (i_arst),
    .i_flush       (i_flush_dec),
    .i_stall       (i_stall_fetch),
    .i_load        (load),
    .i_instr       (load_instr),
    .i_pc          (load_pc),
    .o_instruction (o_instruction),
    .o_pc          (o_pc),
    .o_pc_plus4    (o_pc_plus4),
    .o_instr_valid (o_instr_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic
// against a transaction-level model (in-flight / stale / parked flags).
module tb_fetch_stage;

  localparam int unsigned AW  = 64;
  localparam int unsigned IW  = 32;
  localparam logic [63:0] RPC = 64'h1000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk;
  logic          i_arst, i_stall_fetch, i_flush_dec, i_redirect;
  logic [AW-1:0] i_redirect_pc;
  logic          o_mem_req_valid;
  logic [AW-1:0] o_mem_req_addr;
  logic          i_mem_req_ready, i_mem_rsp_valid;
  logic [IW-1:0] i_mem_rsp_data;
  logic [IW-1:0] o_instruction;
  logic [AW-1:0] o_pc, o_pc_plus4;
  logic          o_instr_valid;

  fetch_stage #(
    .ADDR_WIDTH  (AW),
    .INSTR_WIDTH (IW),
    .RESET_PC    (RPC)
  ) dut (
    .i_clk           (clk),
    .i_arst          (i_arst),
    .i_stall_fetch   (i_stall_fetch),
    .i_flush_dec     (i_flush_dec),
    .i_redirect      (i_redirect),
    .i_redirect_pc   (i_redirect_pc),
    .o_mem_req_valid (o_mem_req_valid),
    .o_mem_req_addr  (o_mem_req_addr),
    .i_mem_req_ready (i_mem_req_ready),
    .i_mem_rsp_valid (i_mem_rsp_valid),
    .i_mem_rsp_data  (i_mem_rsp_data),
    .o_instruction   (o_instruction),
    .o_pc            (o_pc),
    .o_pc_plus4      (o_pc_plus4),
    .o_instr_valid   (o_instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus controls for the next cycle
  bit          c_rst, c_stall, c_flush, c_redir, c_ready;
  logic [63:0] c_rpc;
  int          c_lat;

  // Memory: one pending request, answers c_lat cycles after the cycle following acceptance
  bit          mem_pend;
  int          mem_cnt;
  logic [63:0] mem_addr;

  // Reference model
  logic [63:0] m_pc;
  bit          m_inflight, m_stale, m_held;
  logic [31:0] m_hinstr;
  logic [63:0] m_hpc;
  logic [31:0] e_instr;
  logic [63:0] e_pc, e_pc4;
  bit          e_valid;

  int n_checks = 0;
  int n_err    = 0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc       = RPC;
    m_inflight = 0;
    m_stale    = 0;
    m_held     = 0;
    m_hinstr   = '0;
    m_hpc      = '0;
    e_instr    = NOP;
    e_pc       = '0;
    e_pc4      = '0;
    e_valid    = 0;
  endtask

  // One clock cycle: entered and left at a falling edge
  task automatic cycle();
    bit          rsp, fire, deliver, exp_rv, dut_fire;
    logic [31:0] rdata, d_instr;
    logic [63:0] d_pc, dut_addr;
    deliver = 0;
    d_instr = '0;
    d_pc    = '0;
    rsp     = !c_rst && mem_pend && (mem_cnt == 0);
    rdata   = rsp ? mem_word(mem_addr) : $urandom;

    i_arst          = c_rst;
    i_stall_fetch   = c_stall;
    i_flush_dec     = c_flush;
    i_redirect      = c_redir;
    i_redirect_pc   = c_rpc;
    i_mem_req_ready = c_ready;
    i_mem_rsp_valid = rsp;
    i_mem_rsp_data  = rdata;
    #1;

    exp_rv = !c_rst && !m_inflight && !m_held;
    chk("req_valid", o_mem_req_valid, exp_rv);
    if (exp_rv) chk("req_addr", o_mem_req_addr, m_pc);
    chk("ifid_instr", o_instruction, e_instr);
    chk("ifid_pc", o_pc, e_pc);
    chk("ifid_pc4", o_pc_plus4, e_pc4);
    chk("ifid_valid", o_instr_valid, e_valid);

    dut_fire = o_mem_req_valid && c_ready;
    dut_addr = o_mem_req_addr;
    fire     = exp_rv && c_ready;

    if (c_rst) begin
      model_reset();
    end else begin
      if (c_redir) begin
        m_pc   = c_rpc & ~64'd3;
        m_held = 0;
        if (fire) begin
          m_inflight = 1;
          m_stale    = 1;
        end else if (m_inflight) begin
          if (rsp) begin
            m_inflight = 0;
            m_stale    = 0;
          end else begin
            m_stale = 1;
          end
        end
      end else if (fire) begin
        m_inflight = 1;
        m_stale    = 0;
      end else if (m_inflight && rsp) begin
        m_inflight = 0;
        if (m_stale) begin
          m_stale = 0;
        end else if (c_stall) begin
          m_held   = 1;
          m_hinstr = rdata;
          m_hpc    = m_pc;
        end else begin
          deliver = 1;
          d_instr = rdata;
          d_pc    = m_pc;
          m_pc    = m_pc + 64'd4;
        end
      end else if (m_held && !c_stall) begin
        deliver = 1;
        d_instr = m_hinstr;
        d_pc    = m_hpc;
        m_held  = 0;
        m_pc    = m_pc + 64'd4;
      end
      if (c_flush) begin
        e_instr = NOP; e_pc = '0; e_pc4 = '0; e_valid = 0;
      end else if (!c_stall) begin
        if (deliver) begin
          e_instr = d_instr; e_pc = d_pc; e_pc4 = d_pc + 64'd4; e_valid = 1;
        end else begin
          e_instr = NOP; e_pc = '0; e_pc4 = '0; e_valid = 0;
        end
      end
    end

    @(posedge clk);
    if (c_rst) begin
      mem_pend = 0;
    end else begin
      if (rsp) mem_pend = 0;
      else if (mem_pend && mem_cnt > 0) mem_cnt--;
      if (dut_fire) begin
        mem_pend = 1;
        mem_cnt  = c_lat;
        mem_addr = dut_addr;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    c_rst = 1; c_stall = 0; c_flush = 0; c_redir = 0; c_ready = 1; c_lat = 0; c_rpc = '0;
    mem_pend = 0; mem_cnt = 0; mem_addr = '0;
    i_arst = 1; i_stall_fetch = 0; i_flush_dec = 0; i_redirect = 0; i_redirect_pc = '0;
    i_mem_req_ready = 1; i_mem_rsp_valid = 0; i_mem_rsp_data = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);

    // Reset values
    chk("rst_instr", o_instruction, NOP);
    chk("rst_valid", o_instr_valid, 0);
    chk("rst_pc", o_pc, 0);
    chk("rst_pc4", o_pc_plus4, 0);
    chk("rst_req_valid", o_mem_req_valid, 0);
    chk("rst_addr", o_mem_req_addr, 64'h1000);
    cycle();

    // Zero-wait memory from reset
    c_rst = 0;
    cycle(); cycle();
    chk("t1_pc", o_pc, 64'h1000);
    chk("t1_pc4", o_pc_plus4, 64'h1004);
    chk("t1_valid", o_instr_valid, 1);
    chk("t1_instr", o_instruction, 32'h5A5A_1000);
    chk("t1_addr2", o_mem_req_addr, 64'h1004);
    cycle(); cycle();
    chk("t1_addr3", o_mem_req_addr, 64'h1008);
    cycle(); cycle();

    // Redirect while waiting; response arrives three cycles later and is dropped
    c_lat = 3;
    cycle();
    c_lat = 0; c_redir = 1; c_rpc = 64'h2003;
    cycle();
    c_redir = 0;
    chk("t2_redir_addr", o_mem_req_addr, 64'h2000);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t2_no_old_instr", o_instr_valid, 0);
    end
    chk("t2_req_valid", o_mem_req_valid, 1);
    chk("t2_req_addr", o_mem_req_addr, 64'h2000);
    cycle(); cycle();
    chk("t2_new_pc", o_pc, 64'h2000);
    chk("t2_new_instr", o_instruction, 32'h5A5A_2000);
    chk("t2_new_valid", o_instr_valid, 1);

    // Response lands during a four-cycle stall
    cycle();
    c_stall = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t3_stall_valid", o_instr_valid, 0);
      chk("t3_stall_pc", o_pc, 0);
      chk("t3_stall_addr", o_mem_req_addr, 64'h2004);
    end
    c_stall = 0;
    cycle();
    chk("t3_pc", o_pc, 64'h2004);
    chk("t3_valid", o_instr_valid, 1);
    chk("t3_pc_adv", o_mem_req_addr, 64'h2008);

    // Flush together with stall, then memory refuses for five cycles
    c_stall = 1; c_flush = 1; c_ready = 0;
    cycle();
    c_stall = 0; c_flush = 0;
    chk("t4_instr", o_instruction, NOP);
    chk("t4_valid", o_instr_valid, 0);
    chk("t4_pc", o_pc, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t5_req_valid", o_mem_req_valid, 1);
      chk("t5_addr", o_mem_req_addr, 64'h2008);
      chk("t5_valid", o_instr_valid, 0);
      cycle();
    end
    chk("t5_addr_end", o_mem_req_addr, 64'h2008);

    // PC wrap at the top of the address space
    c_redir = 1; c_rpc = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle();
    c_redir = 0; c_ready = 1;
    chk("t6_addr", o_mem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(); cycle();
    chk("t6_pc", o_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t6_pc4", o_pc_plus4, 64'h0);
    chk("t6_valid", o_instr_valid, 1);
    chk("t6_next_addr", o_mem_req_addr, 64'h0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      c_rst   = ($urandom_range(0, 299) == 0);
      c_stall = ($urandom_range(0, 3) == 0);
      c_flush = ($urandom_range(0, 15) == 0);
      c_redir = ($urandom_range(0, 11) == 0);
      c_rpc   = {$urandom, $urandom};
      c_ready = ($urandom_range(0, 2) != 0);
      c_lat   = $urandom_range(0, 3);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
